fp_norm_pack: RTL and testbench

- Back end of the single-precision add/sub datapath. Consumes the 25-bit signed-magnitude fraction result and the larger operand's biased exponent from the align/add stage.
- Normalises by iterative shifting, one left shift per cycle, and detects overflow and underflow.
- Packs the IEEE-754 binary32 word. Truncates; no rounding.
- Valid/ready handshake on both sides; single transaction in flight.

---
 rtl/fp_norm_pack.sv | 223 ++++++++++++++++++++++
 tb/tb_fp_norm_pack.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_pack.sv
// -----------------------------------------------------------------------------
// fp_norm_pack
//
// Back end of the single-precision add/sub datapath. Takes the signed-magnitude
// fraction produced by the align/add stage, together with the larger operand's
// biased exponent. It normalises the fraction with one left shift per cycle,
// detects overflow (infinity), zero and underflow (denormal), and packs an
// IEEE-754 binary32 word. The shifted-out bit is truncated; there is no rounding.
// Only one transaction is in flight at a time.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : sum / sign_in / exp_in are valid
//   in_ready   : block idle, a new operand is accepted this edge
//   sum        : adder magnitude; [MAN_W+1] is the carry, [MAN_W] the hidden bit
//   sign_in    : result sign from the adder
//   exp_in     : biased exponent of the larger operand
//   out_valid  : result and flags valid
//   out_ready  : downstream accepts the result
//   result     : {sign, exp, man}
//   flag_zero  : result is +0
//   flag_ovf   : result is infinity
//   flag_unf   : nonzero sum produced a denormal result
//   norm_shift : number of left shifts performed (debug)
// -----------------------------------------------------------------------------
module fp_norm_pack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MAN_W+1:0]         sum,
  input  logic                     sign_in,
  input  logic [EXP_W-1:0]         exp_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     flag_zero,
  output logic                     flag_ovf,
  output logic                     flag_unf,
  output logic [4:0]               norm_shift
);

  localparam int RES_W = EXP_W + MAN_W + 1;

  // The working exponent carries one extra bit so that e+1 never wraps.
  localparam logic [EXP_W:0]   E_MAX  = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0]   E_ONE  = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0]   E_ZERO = '0;
  localparam logic [EXP_W-1:0] EF_MAX = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EF_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0] EF_ZERO = '0;
  localparam logic [MAN_W-1:0] MF_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  // Assemble a packed word from its three fields.
  function automatic logic [RES_W-1:0] pack_word(
    input logic             s,
    input logic [EXP_W-1:0] e,
    input logic [MAN_W-1:0] m
  );
    return {s, e, m};
  endfunction

  // Shift counter never wraps back to zero.
  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  state_t             state_q,   state_d;
  logic [MAN_W+1:0]   m_q,       m_d;
  logic [EXP_W:0]     e_q,       e_d;
  logic               s_q,       s_d;
  logic               in_rdy_q,  in_rdy_d;
  logic               ovld_q,    ovld_d;
  logic [RES_W-1:0]   res_q,     res_d;
  logic               zero_q,    zero_d;
  logic               ovf_q,     ovf_d;
  logic               unf_q,     unf_d;
  logic [4:0]         nsh_q,     nsh_d;
  logic [EXP_W:0]     e_inc;
  logic               finish;

  assign e_inc = e_q + E_ONE;

  // Next-state and output computation. Outputs are all registered, so the
  // handshake inputs never reach in_ready combinationally.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    e_d      = e_q;
    s_d      = s_q;
    in_rdy_d = in_rdy_q;
    ovld_d   = ovld_q;
    res_d    = res_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    nsh_d    = nsh_q;
    finish   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d      = sum;
          e_d      = {1'b0, exp_in};
          s_d      = sign_in;
          nsh_d    = 5'd0;
          in_rdy_d = 1'b0;
          state_d  = NORM;
        end
      end

      NORM: begin
        if (e_q == E_MAX) begin
          // Larger operand was already Inf/NaN-class exponent: saturate.
          res_d  = pack_word(s_q, EF_MAX, MF_ZERO);
          ovf_d  = 1'b1;
          finish = 1'b1;
        end else if (m_q == '0) begin
          // Exact cancellation always yields +0, whatever the adder sign.
          res_d  = '0;
          zero_d = 1'b1;
          finish = 1'b1;
        end else if (m_q[MAN_W+1]) begin
          // Carry out: one right shift, LSB dropped (truncation).
          if (e_inc == E_MAX) begin
            res_d = pack_word(s_q, EF_MAX, MF_ZERO);
            ovf_d = 1'b1;
          end else begin
            res_d = pack_word(s_q, e_inc[EXP_W-1:0], m_q[MAN_W:1]);
          end
          finish = 1'b1;
        end else if (m_q[MAN_W]) begin
          // Hidden bit in place. A zero exponent with the hidden bit set is
          // the smallest normal, so the field becomes 1.
          res_d  = pack_word(s_q, (e_q == E_ZERO) ? EF_ONE : e_q[EXP_W-1:0],
                             m_q[MAN_W-1:0]);
          finish = 1'b1;
        end else if (e_q <= E_ONE) begin
          // Cannot shift further: exponent fields 1 and 0 share one scale,
          // so the remaining fraction is emitted as a denormal.
          res_d  = pack_word(s_q, EF_ZERO, m_q[MAN_W-1:0]);
          unf_d  = 1'b1;
          finish = 1'b1;
        end else begin
          m_d   = m_q << 1;
          e_d   = e_q - E_ONE;
          nsh_d = sat_inc5(nsh_q);
        end

        if (finish) begin
          ovld_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        // Result and norm_shift stay as they are after the handshake.
        if (out_ready) begin
          ovld_d   = 1'b0;
          zero_d   = 1'b0;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          in_rdy_d = 1'b1;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        in_rdy_d = 1'b1;
        ovld_d   = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset aborts any transaction in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      m_q      <= '0;
      e_q      <= '0;
      s_q      <= 1'b0;
      in_rdy_q <= 1'b1;
      ovld_q   <= 1'b0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      nsh_q    <= 5'd0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      e_q      <= e_d;
      s_q      <= s_d;
      in_rdy_q <= in_rdy_d;
      ovld_q   <= ovld_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      nsh_q    <= nsh_d;
    end
  end

  assign in_ready   = in_rdy_q;
  assign out_valid  = ovld_q;
  assign result     = res_q;
  assign flag_zero  = zero_q;
  assign flag_ovf   = ovf_q;
  assign flag_unf   = unf_q;
  assign norm_shift = nsh_q;

endmodule

// File: tb/tb_fp_norm_pack.sv
// Directed, table-driven bench for fp_norm_pack.
module tb_fp_norm_pack;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] sum;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_zero;
  logic        flag_ovf;
  logic        flag_unf;
  logic [4:0]  norm_shift;

  int total = 0;
  int bad   = 0;

  fp_norm_pack #(.EXP_W(8), .MAN_W(23)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum        (sum),
    .sign_in    (sign_in),
    .exp_in     (exp_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_ovf   (flag_ovf),
    .flag_unf   (flag_unf),
    .norm_shift (norm_shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [24:0] sum;
    logic        sgn;
    logic [7:0]  exp;
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        u;
    logic [4:0]  ns;
    int          lat;
    bit          pulse;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Launch one transaction, follow it to out_valid, check, hold for `hold`
  // cycles with out_ready low, then complete the handshake.
  task automatic apply(input vec_t v, input int hold);
    int          lat;
    bit          busy_ok;
    bit          stable_ok;
    logic [31:0] held;
    chk({v.name, ".in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    sum      = v.sum;
    sign_in  = v.sgn;
    exp_in   = v.exp;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 0;
    busy_ok  = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      if (v.pulse && lat == 5) begin
        sum = 25'h1FF_FFFF; sign_in = 1'b1; exp_in = 8'd200; in_valid = 1'b1;
      end
      if (v.pulse && lat == 7) in_valid = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk({v.name, ".latency"}, lat, v.lat);
    chk({v.name, ".in_ready_busy"}, {31'd0, busy_ok}, 32'd1);
    chk({v.name, ".result"}, result, v.res);
    chk({v.name, ".flags"}, {29'd0, flag_zero, flag_ovf, flag_unf}, {29'd0, v.z, v.o, v.u});
    chk({v.name, ".norm_shift"}, {27'd0, norm_shift}, {27'd0, v.ns});
    if (hold > 0) begin
      held      = result;
      stable_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || result !== held || in_ready !== 1'b0) stable_ok = 1'b0;
      end
      chk({v.name, ".backpressure_hold"}, {31'd0, stable_ok}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({v.name, ".out_valid_cleared"}, {31'd0, out_valid}, 32'd0);
    chk({v.name, ".in_ready_back"}, {31'd0, in_ready}, 32'd1);
    chk({v.name, ".flags_cleared"}, {29'd0, flag_zero, flag_ovf, flag_unf}, 32'd0);
    chk({v.name, ".result_kept"}, result, v.res);
  endtask

  initial begin
    int  cnt;
    bit  seen;

    vecs[0] = '{"one",     25'h080_0000, 1'b0, 8'd127, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 5'd0,  1,  1'b0};
    vecs[1] = '{"neg_two", 25'h100_0000, 1'b1, 8'd127, 32'hC000_0000, 1'b0, 1'b0, 1'b0, 5'd0,  1,  1'b0};
    vecs[2] = '{"long",    25'h000_0001, 1'b0, 8'd127, 32'h3400_0000, 1'b0, 1'b0, 1'b0, 5'd23, 24, 1'b1};
    vecs[3] = '{"zero",    25'h000_0000, 1'b1, 8'd50,  32'h0000_0000, 1'b1, 1'b0, 1'b0, 5'd0,  1,  1'b0};
    vecs[4] = '{"ovf_car", 25'h100_0000, 1'b0, 8'd254, 32'h7F80_0000, 1'b0, 1'b1, 1'b0, 5'd0,  1,  1'b0};
    vecs[5] = '{"denorm",  25'h000_0100, 1'b0, 8'd3,   32'h0000_0400, 1'b0, 1'b0, 1'b1, 5'd2,  3,  1'b0};
    vecs[6] = '{"exp_max", 25'h080_0000, 1'b1, 8'd255, 32'hFF80_0000, 1'b0, 1'b1, 1'b0, 5'd0,  1,  1'b0};
    vecs[7] = '{"exp0_hb", 25'h080_0000, 1'b0, 8'd0,   32'h0080_0000, 1'b0, 1'b0, 1'b0, 5'd0,  1,  1'b0};
    vecs[8] = '{"trunc",   25'h1FF_FFFF, 1'b0, 8'd100, 32'h32FF_FFFF, 1'b0, 1'b0, 1'b0, 5'd0,  1,  1'b0};
    vecs[9] = '{"unf_e1",  25'h040_0000, 1'b0, 8'd1,   32'h0040_0000, 1'b0, 1'b0, 1'b1, 5'd0,  1,  1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum       = '0;
    sign_in   = 1'b0;
    exp_in    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    chk("reset.in_ready",   {31'd0, in_ready},  32'd1);
    chk("reset.out_valid",  {31'd0, out_valid}, 32'd0);
    chk("reset.result",     result,             32'd0);
    chk("reset.flags",      {29'd0, flag_zero, flag_ovf, flag_unf}, 32'd0);
    chk("reset.norm_shift", {27'd0, norm_shift}, 32'd0);

    for (int i = 0; i < 10; i++) apply(vecs[i], 0);

    // Backpressure: out_ready low for three cycles after out_valid.
    apply(vecs[0], 3);

    // Reset in the middle of a long normalisation.
    sum      = vecs[2].sum;
    sign_in  = vecs[2].sgn;
    exp_in   = vecs[2].exp;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("abort.shift_before_reset", {27'd0, norm_shift}, 32'd10);
    rst_n = 1'b0;
    #1;
    chk("abort.in_ready",   {31'd0, in_ready},  32'd1);
    chk("abort.out_valid",  {31'd0, out_valid}, 32'd0);
    chk("abort.result",     result,             32'd0);
    chk("abort.norm_shift", {27'd0, norm_shift}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    cnt  = 0;
    while (cnt < 30) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
      cnt++;
    end
    chk("abort.no_output", {31'd0, seen}, 32'd0);
    apply(vecs[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
